// File: rtl/id_stage_pipelined.sv
// RV32I decode stage: register file, instruction decode, load-use hazard detection
// and the ID/EX pipeline register feeding the execute stage.
module id_stage_pipelined #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int BYPASS_EN = 1,
    parameter int HAZARD_EN = 1,
    localparam int RA       = $clog2(REG_COUNT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            ex_stall,
    input  logic            wb_we,
    input  logic [RA-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA-1:0]   ex_rs1,
    output logic [RA-1:0]   ex_rs2,
    output logic [RA-1:0]   ex_rd,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_memread,
    output logic            ex_memtoreg,
    output logic            ex_memwrite,
    output logic            ex_alusrc,
    output logic            ex_regwrite,
    output logic [1:0]      ex_aluop,
    output logic            ex_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Widens a 32-bit immediate to the datapath width with sign extension.
    function automatic logic signed [XLEN-1:0] sext(input logic signed [31:0] v);
        return v;
    endfunction

    logic [XLEN-1:0]        regs [REG_COUNT];
    logic [RA-1:0]          rs1_d, rs2_d, rd_d;
    logic [XLEN-1:0]        rs1_data_d, rs2_data_d;
    logic signed [XLEN-1:0] imm_d;
    logic                   use_rs1_d, use_rs2_d;
    logic                   branch_d, jump_d, memread_d, memtoreg_d, memwrite_d;
    logic                   alusrc_d, regwrite_d, illegal_d;
    logic [1:0]             aluop_d;
    logic                   hazard, kill, load;

    assign rs1_d = if_instr[15 +: RA];
    assign rs2_d = if_instr[20 +: RA];
    assign rd_d  = if_instr[7 +: RA];

    // Register file; x0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (wb_we && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rs1_data_d = '0;
        rs2_data_d = '0;
        if (rs1_d != '0)
            rs1_data_d = (BYPASS_EN != 0 && wb_we && wb_rd == rs1_d) ? wb_data : regs[rs1_d];
        if (rs2_d != '0)
            rs2_data_d = (BYPASS_EN != 0 && wb_we && wb_rd == rs2_d) ? wb_data : regs[rs2_d];
    end

    // Control decode; an empty IF/ID slot decodes to all-zero control
    always_comb begin
        imm_d      = '0;
        use_rs1_d  = 1'b0;
        use_rs2_d  = 1'b0;
        branch_d   = 1'b0;
        jump_d     = 1'b0;
        memread_d  = 1'b0;
        memtoreg_d = 1'b0;
        memwrite_d = 1'b0;
        alusrc_d   = 1'b0;
        regwrite_d = 1'b0;
        illegal_d  = 1'b0;
        aluop_d    = 2'b00;
        if (if_valid) begin
            case (if_instr[6:0])
                OP_R: begin
                    use_rs1_d = 1'b1; use_rs2_d = 1'b1; regwrite_d = 1'b1; aluop_d = 2'b10;
                end
                OP_IALU: begin
                    imm_d = sext({{20{if_instr[31]}}, if_instr[31:20]});
                    use_rs1_d = 1'b1; alusrc_d = 1'b1; regwrite_d = 1'b1; aluop_d = 2'b11;
                end
                OP_LOAD: begin
                    imm_d = sext({{20{if_instr[31]}}, if_instr[31:20]});
                    use_rs1_d = 1'b1; alusrc_d = 1'b1; regwrite_d = 1'b1;
                    memread_d = 1'b1; memtoreg_d = 1'b1;
                end
                OP_STORE: begin
                    imm_d = sext({{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]});
                    use_rs1_d = 1'b1; use_rs2_d = 1'b1; alusrc_d = 1'b1; memwrite_d = 1'b1;
                end
                OP_BRANCH: begin
                    imm_d = sext({{19{if_instr[31]}}, if_instr[31], if_instr[7],
                                  if_instr[30:25], if_instr[11:8], 1'b0});
                    use_rs1_d = 1'b1; use_rs2_d = 1'b1; branch_d = 1'b1; aluop_d = 2'b01;
                end
                OP_JAL: begin
                    imm_d = sext({{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                                  if_instr[20], if_instr[30:21], 1'b0});
                    jump_d = 1'b1; regwrite_d = 1'b1;
                end
                OP_JALR: begin
                    imm_d = sext({{20{if_instr[31]}}, if_instr[31:20]});
                    use_rs1_d = 1'b1; jump_d = 1'b1; alusrc_d = 1'b1; regwrite_d = 1'b1;
                end
                OP_LUI, OP_AUIPC: begin
                    imm_d = sext({if_instr[31:12], 12'b0});
                    alusrc_d = 1'b1; regwrite_d = 1'b1;
                end
                default: illegal_d = 1'b1;
            endcase
        end
    end

    assign hazard = (HAZARD_EN != 0) && if_valid && ex_valid && ex_memread && (ex_rd != '0) &&
                    ((use_rs1_d && ex_rd == rs1_d) || (use_rs2_d && ex_rd == rs2_d));
    assign kill     = flush || (!ex_stall && hazard);
    assign load     = !flush && !ex_stall && !hazard;
    assign id_ready = !rst && (flush || (!ex_stall && !hazard));

    // ID/EX boundary: kill inserts a bubble with cleared control, stall holds everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0; ex_pc <= '0; ex_rs1_data <= '0; ex_rs2_data <= '0; ex_imm <= '0;
            ex_rs1 <= '0; ex_rs2 <= '0; ex_rd <= '0;
            ex_branch <= 1'b0; ex_jump <= 1'b0; ex_memread <= 1'b0; ex_memtoreg <= 1'b0;
            ex_memwrite <= 1'b0; ex_alusrc <= 1'b0; ex_regwrite <= 1'b0; ex_aluop <= 2'b00;
            ex_illegal <= 1'b0;
        end else if (kill) begin
            ex_valid <= 1'b0;
            ex_branch <= 1'b0; ex_jump <= 1'b0; ex_memread <= 1'b0; ex_memtoreg <= 1'b0;
            ex_memwrite <= 1'b0; ex_alusrc <= 1'b0; ex_regwrite <= 1'b0; ex_aluop <= 2'b00;
            ex_illegal <= 1'b0;
        end else if (load) begin
            ex_valid <= if_valid; ex_pc <= if_pc; ex_rs1_data <= rs1_data_d;
            ex_rs2_data <= rs2_data_d; ex_imm <= imm_d;
            ex_rs1 <= rs1_d; ex_rs2 <= rs2_d; ex_rd <= rd_d;
            ex_branch <= branch_d; ex_jump <= jump_d; ex_memread <= memread_d;
            ex_memtoreg <= memtoreg_d; ex_memwrite <= memwrite_d; ex_alusrc <= alusrc_d;
            ex_regwrite <= regwrite_d; ex_aluop <= aluop_d; ex_illegal <= illegal_d;
        end
    end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: a default instance plus one built with
// bypass and hazard detection disabled, both driven from the same inputs.
module tb_id_stage_pipelined;

    logic        clk = 1'b0;
    logic        rst, if_valid, flush, ex_stall, wb_we;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [4:0]  wb_rd;

    logic        id_ready, ex_valid, ex_branch, ex_jump, ex_memread, ex_memtoreg;
    logic        ex_memwrite, ex_alusrc, ex_regwrite, ex_illegal;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [1:0]  ex_aluop;

    logic        nb_id_ready, nb_ex_valid, nb_ex_branch, nb_ex_jump, nb_ex_memread, nb_ex_memtoreg;
    logic        nb_ex_memwrite, nb_ex_alusrc, nb_ex_regwrite, nb_ex_illegal;
    logic [31:0] nb_ex_pc, nb_ex_rs1_data, nb_ex_rs2_data, nb_ex_imm;
    logic [4:0]  nb_ex_rs1, nb_ex_rs2, nb_ex_rd;
    logic [1:0]  nb_ex_aluop;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    id_stage_pipelined dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .ex_stall(ex_stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_ready(id_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_memread(ex_memread),
        .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
        .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop), .ex_illegal(ex_illegal)
    );

    id_stage_pipelined #(.BYPASS_EN(0), .HAZARD_EN(0)) dut_nb (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .ex_stall(ex_stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_ready(nb_id_ready), .ex_valid(nb_ex_valid), .ex_pc(nb_ex_pc),
        .ex_rs1_data(nb_ex_rs1_data), .ex_rs2_data(nb_ex_rs2_data), .ex_imm(nb_ex_imm),
        .ex_rs1(nb_ex_rs1), .ex_rs2(nb_ex_rs2), .ex_rd(nb_ex_rd), .ex_branch(nb_ex_branch),
        .ex_jump(nb_ex_jump), .ex_memread(nb_ex_memread), .ex_memtoreg(nb_ex_memtoreg),
        .ex_memwrite(nb_ex_memwrite), .ex_alusrc(nb_ex_alusrc), .ex_regwrite(nb_ex_regwrite),
        .ex_aluop(nb_ex_aluop), .ex_illegal(nb_ex_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        flush = 1'b0; ex_stall = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;

        // Reset state
        #2;
        chk("rst_id_ready", {31'b0, id_ready}, 32'd0);
        tick; tick;
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_id_ready", {31'b0, id_ready}, 32'd1);

        // WB x1=5, then ADDI x3,x1,7
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        tick;
        wb_we = 1'b0;
        issue(32'h00708193, 32'h100);
        tick;
        chk("addi_valid", {31'b0, ex_valid}, 32'd1);
        chk("addi_rs1", ex_rs1_data, 32'd5);
        chk("addi_imm", ex_imm, 32'd7);
        chk("addi_aluop", {30'b0, ex_aluop}, 32'd3);
        chk("addi_alusrc", {31'b0, ex_alusrc}, 32'd1);
        chk("addi_regwrite", {31'b0, ex_regwrite}, 32'd1);
        chk("addi_pc", ex_pc, 32'h100);
        chk("addi_rd", {27'b0, ex_rd}, 32'd3);

        // Same-cycle WB x2 with ADD x3,x1,x2
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hA5A5A5A5;
        issue(32'h002081B3, 32'h104);
        tick;
        wb_we = 1'b0;
        chk("add_bypass_rs2", ex_rs2_data, 32'hA5A5A5A5);
        chk("add_rs1", ex_rs1_data, 32'd5);
        chk("add_aluop", {30'b0, ex_aluop}, 32'd2);
        chk("nb_add_old_rs2", nb_ex_rs2_data, 32'd0);

        // Load-use: LW x5,0(x1) then ADD x6,x5,x2
        issue(32'h0000A283, 32'h108);
        tick;
        chk("lw_memread", {31'b0, ex_memread}, 32'd1);
        chk("lw_memtoreg", {31'b0, ex_memtoreg}, 32'd1);
        chk("lw_rd", {27'b0, ex_rd}, 32'd5);
        issue(32'h00228333, 32'h10C);
        #1;
        chk("hz_id_ready", {31'b0, id_ready}, 32'd0);
        chk("nb_hz_id_ready", {31'b0, nb_id_ready}, 32'd1);
        tick;
        chk("bubble_valid", {31'b0, ex_valid}, 32'd0);
        chk("bubble_memread", {31'b0, ex_memread}, 32'd0);
        chk("bubble_regwrite", {31'b0, ex_regwrite}, 32'd0);
        chk("nb_nobubble_valid", {31'b0, nb_ex_valid}, 32'd1);
        chk("nb_nobubble_rd", {27'b0, nb_ex_rd}, 32'd6);
        chk("after_bubble_ready", {31'b0, id_ready}, 32'd1);
        tick;
        chk("add6_valid", {31'b0, ex_valid}, 32'd1);
        chk("add6_rd", {27'b0, ex_rd}, 32'd6);
        chk("add6_rs2", ex_rs2_data, 32'hA5A5A5A5);
        chk("add6_pc", ex_pc, 32'h10C);

        // Stall for 3 cycles, with a WB x1=9 committed during the first
        issue(32'h00708193, 32'h110);
        ex_stall = 1'b1;
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd9;
        #1;
        chk("stall_id_ready", {31'b0, id_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            wb_we = 1'b0;
            chk("stall_hold_rd", {27'b0, ex_rd}, 32'd6);
            chk("stall_hold_pc", ex_pc, 32'h10C);
            chk("stall_hold_valid", {31'b0, ex_valid}, 32'd1);
            chk("stall_ready", {31'b0, id_ready}, 32'd0);
        end
        ex_stall = 1'b0;
        tick;
        chk("post_stall_rd", {27'b0, ex_rd}, 32'd3);
        chk("post_stall_rs1", ex_rs1_data, 32'd9);

        // Flush overrides stall
        ex_stall = 1'b1; flush = 1'b1;
        #1;
        chk("flush_id_ready", {31'b0, id_ready}, 32'd1);
        tick;
        chk("flush_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush_regwrite", {31'b0, ex_regwrite}, 32'd0);
        flush = 1'b0; ex_stall = 1'b0;

        // x0 write ignored, also on the bypass path
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
        issue(32'h000001B3, 32'h120);
        tick;
        chk("x0_bypass_rs1", ex_rs1_data, 32'd0);
        chk("x0_bypass_rs2", ex_rs2_data, 32'd0);
        wb_we = 1'b0;
        tick;
        chk("x0_read", ex_rs1_data, 32'd0);

        // BEQ x1,x2,-4
        issue(32'hFE208EE3, 32'h124);
        tick;
        chk("beq_imm", ex_imm, 32'hFFFFFFFC);
        chk("beq_branch", {31'b0, ex_branch}, 32'd1);
        chk("beq_aluop", {30'b0, ex_aluop}, 32'd1);
        chk("beq_regwrite", {31'b0, ex_regwrite}, 32'd0);

        // SW x2,8(x1)
        issue(32'h0020A423, 32'h128);
        tick;
        chk("sw_imm", ex_imm, 32'd8);
        chk("sw_memwrite", {31'b0, ex_memwrite}, 32'd1);
        chk("sw_regwrite", {31'b0, ex_regwrite}, 32'd0);
        chk("sw_rs2", ex_rs2_data, 32'hA5A5A5A5);

        // LUI x7,0x12345
        issue(32'h123453B7, 32'h12C);
        tick;
        chk("lui_imm", ex_imm, 32'h12345000);
        chk("lui_alusrc", {31'b0, ex_alusrc}, 32'd1);

        // Illegal opcode 0x7F
        issue(32'h0000007F, 32'h130);
        tick;
        chk("ill_flag", {31'b0, ex_illegal}, 32'd1);
        chk("ill_regwrite", {31'b0, ex_regwrite}, 32'd0);
        chk("ill_memread", {31'b0, ex_memread}, 32'd0);

        // JAL x1,+8
        issue(32'h008000EF, 32'h200);
        tick;
        chk("jal_imm", ex_imm, 32'd8);
        chk("jal_jump", {31'b0, ex_jump}, 32'd1);
        chk("jal_regwrite", {31'b0, ex_regwrite}, 32'd1);

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, ex_valid}, 32'd0);
        chk("arst_imm", ex_imm, 32'd0);
        chk("arst_pc", ex_pc, 32'd0);
        chk("arst_jump", {31'b0, ex_jump}, 32'd0);
        chk("arst_id_ready", {31'b0, id_ready}, 32'd0);
        tick;
        rst = 1'b0;
        issue(32'h002081B3, 32'h300);
        tick;
        chk("arst_x1_cleared", ex_rs1_data, 32'd0);
        chk("arst_x2_cleared", ex_rs2_data, 32'd0);
        chk("arst_resume_valid", {31'b0, ex_valid}, 32'd1);

        if_valid = 1'b0;
        tick;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
